// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the bit-serial adder controller.
//   state_t        : FSM state encoding (IDLE=0, ADD=1, DONE=2), 2 bits wide.
//                    The top module exports it on its debug port.
//   DEFAULT_WIDTH  : operand width used when the top is not overridden.
// -----------------------------------------------------------------------------
package adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : adder_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// Purely combinational 1-bit full adder. It holds no state. It is the only
// arithmetic on operand data in the serial adder.
//   a, b, cin : input bits
//   sum       : a ^ b ^ cin
//   cout      : majority(a, b, cin)
// -----------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder. A single full adder is stepped across the operands,
// least significant bit first, at one bit per clock.
//
// Ports
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, takes priority over start
//   start  : request to add, only looked at in IDLE
//   a, b   : WIDTH-bit operands, captured on the accepting edge
//   cin    : carry-in, captured on the accepting edge
//   busy   : high for the WIDTH cycles of the addition
//   done   : one-cycle pulse, result valid from this cycle onward
//   sum    : WIDTH-bit result, held until the next accepted start
//   cout   : final carry-out, held like sum
//   state  : debug view of the FSM state
//
// Handshake: start is a level request. The edge that samples start=1 while
// the FSM is in IDLE accepts the request and captures a, b and cin. The block
// ignores start while busy or done is high, and it does not queue requests.
// busy and done are decoded from disjoint states, so they are never high
// together. sum and cout carry no meaning while busy is high.
// -----------------------------------------------------------------------------
module serial_add_ctrl
   import adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output state_t           state
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   // The counter value in the last ADD cycle. At that point WIDTH bits have
   // been added.
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state_r;
   state_t           state_nx;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] sum_r;
   logic [WIDTH-1:0] sum_nx;
   logic             carry_r;
   logic [CNT_W-1:0] cnt_r;
   logic             fa_sum;
   logic             fa_cout;

   full_adder u_full_adder (
      .a    (a_r[0]),
      .b    (b_r[0]),
      .cin  (carry_r),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state_r;
      case (state_r)
         IDLE:    if (start) state_nx = ADD;
         ADD:     if (cnt_r == LAST_BIT) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // The new sum bit enters at the MSB. After WIDTH shifts the LSB of the
   // result sits at bit 0. For WIDTH=1 the shift leaves zero and the bit
   // overwrites it, so no special case is needed.
   always_comb begin
      sum_nx            = sum_r >> 1;
      sum_nx[WIDTH-1]   = fa_sum;
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r     <= '0;
         b_r     <= '0;
         sum_r   <= '0;
         carry_r <= 1'b0;
         cnt_r   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  a_r     <= a;
                  b_r     <= b;
                  carry_r <= cin;
                  cnt_r   <= '0;
               end
            end
            ADD: begin
               a_r     <= a_r >> 1;
               b_r     <= b_r >> 1;
               sum_r   <= sum_nx;
               carry_r <= fa_cout;
               cnt_r   <= cnt_r + CNT_W'(1);
            end
            default: begin
               // DONE: hold the result
            end
         endcase
      end
   end

   assign busy  = (state_r == ADD);
   assign done  = (state_r == DONE);
   assign sum   = sum_r;
   // After the last ADD cycle, carry_r holds the final carry-out. The next
   // accepted start replaces it.
   assign cout  = carry_r;
   assign state = state_r;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Runs a WIDTH=8 instance and a WIDTH=1 instance side by side. A cycle-level
// model records, for each instance, the edge at which a request was accepted
// and the arithmetic result a+b+cin. busy, done, state, sum and cout are
// derived from that record every cycle.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;
  import adder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  // ---------------- DUT signals ----------------
  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  state_t     state8;

  logic       start1 = 1'b0, cin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;
  state_t     state1;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .state(state8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .state(state1)
  );

  // ---------------- scoreboard counters ----------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // edge_no counts rising edges. The cycle that ends at edge n is "cycle n".
  // A request is accepted at edge n when the block is idle during cycle n:
  // either nothing is pending, or the previous operation (accepted at t,
  // with done in cycle t+W+1) has already finished.
  int          edge_no = 0;
  bit          live[2];
  int          t_acc[2];
  logic [32:0] res[2];
  int          wv[2] = '{8, 1};

  task automatic model_step(input int i, input logic r, input logic s,
                            input logic [31:0] av, input logic [31:0] bv, input logic cv);
    if (r) begin
      live[i]  = 1'b1;
      t_acc[i] = -1;
    end else if (live[i] && s && (t_acc[i] < 0 || edge_no >= t_acc[i] + wv[i] + 2)) begin
      t_acc[i] = edge_no;
      res[i]   = {1'b0, av} + {1'b0, bv} + {32'd0, cv};
    end
  endtask

  always @(posedge clk) begin
    edge_no = edge_no + 1;
    model_step(0, rst, start8, {24'd0, a8}, {24'd0, b8}, cin8);
    model_step(1, rst, start1, {31'd0, a1}, {31'd0, b1}, cin1);
  end

  // Check one instance in the current cycle, which is cycle edge_no+1.
  task automatic check_dut(input int i, input logic bz, input logic dn,
                           input logic [31:0] sm, input logic co, input state_t st);
    int          n, ta, w;
    logic        eb, ed;
    logic [32:0] mask;
    state_t      es;
    string       tag;
    n    = edge_no;
    ta   = t_acc[i];
    w    = wv[i];
    mask = (33'd1 << w) - 33'd1;
    eb   = (ta >= 0) && (n >= ta) && (n < ta + w);
    ed   = (ta >= 0) && (n == ta + w);
    es   = eb ? ADD : (ed ? DONE : IDLE);
    tag  = (i == 0) ? "w8" : "w1";
    chk({tag, " busy"}, {32'd0, bz}, {32'd0, eb});
    chk({tag, " done"}, {32'd0, dn}, {32'd0, ed});
    chk({tag, " state"}, {31'd0, st}, {31'd0, es});
    if (ta < 0) begin
      chk({tag, " reset sum"}, {1'b0, sm}, 33'd0);
      chk({tag, " reset cout"}, {32'd0, co}, 33'd0);
    end else if (n >= ta + w) begin
      chk({tag, " sum"}, {1'b0, sm}, res[i] & mask);
      chk({tag, " cout"}, {32'd0, co}, {32'd0, res[i][w]});
    end
  endtask

  always @(negedge clk) begin
    if (live[0]) check_dut(0, busy8, done8, {24'd0, sum8}, cout8, state8);
    if (live[1]) check_dut(1, busy1, done1, {31'd0, sum1}, cout1, state1);
  end

  // ---------------- driver tasks ----------------
  // Start one WIDTH=8 addition from IDLE, scramble the operands after the
  // accepting edge, then pin latency, busy length and the result to literals.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                     input logic [7:0] es, input logic ec, input string nm);
    int idx, nbusy;
    bit seen;
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    idx = 1; nbusy = 0; seen = 1'b0;
    while (idx <= 20 && !seen) begin
      if (done8) seen = 1'b1;
      else begin
        if (busy8) nbusy++;
        @(negedge clk);
        idx++;
      end
    end
    chk({nm, " latency"}, 33'(idx), 33'd9);
    chk({nm, " busy cycles"}, 33'(nbusy), 33'd8);
    chk({nm, " sum"}, {25'd0, sum8}, {25'd0, es});
    chk({nm, " cout"}, {32'd0, cout8}, {32'd0, ec});
  endtask

  task automatic op1(input int v);
    int   idx;
    bit   seen;
    logic [1:0] exp2;
    @(negedge clk);
    a1 = 1'(v); b1 = 1'(v >> 1); cin1 = 1'(v >> 2); start1 = 1'b1;
    exp2 = 2'(v & 1) + 2'((v >> 1) & 1) + 2'((v >> 2) & 1);
    @(negedge clk);
    start1 = 1'b0; a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
    idx = 1; seen = 1'b0;
    while (idx <= 10 && !seen) begin
      if (done1) seen = 1'b1;
      else begin
        @(negedge clk);
        idx++;
      end
    end
    chk($sformatf("w1 case %0d latency", v), 33'(idx), 33'd2);
    chk($sformatf("w1 case %0d result", v), {31'd0, cout1, sum1}, {31'd0, exp2});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int ndone;
    repeat (3) @(negedge clk);
    chk("reset state", {31'd0, state8}, {31'd0, IDLE});
    chk("reset sum", {25'd0, sum8}, 33'd0);
    chk("reset busy", {32'd0, busy8}, 33'd0);
    rst = 1'b0;

    // Directed operations with hand-computed results
    op8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "5A+3C");
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "FF+01");
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "FF+FF+1");

    // Start re-pulsed with new operands mid-ADD must be ignored
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h7E; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0;
    for (int idx = 1; idx <= 20; idx++) begin
      if (idx == 3) begin start8 = 1'b1; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; end
      if (idx == 4) start8 = 1'b0;
      if (done8) begin
        ndone++;
        chk("repulse pos", 33'(idx), 33'd9);
        chk("repulse sum", {25'd0, sum8}, 33'h42);
        chk("repulse cout", {32'd0, cout8}, 33'd1);
      end
      @(negedge clk);
    end
    chk("repulse done count", 33'(ndone), 33'd1);

    // Reset mid-ADD aborts without a done pulse
    @(negedge clk);
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", {32'd0, busy8}, 33'd0);
    chk("abort done", {32'd0, done8}, 33'd0);
    chk("abort sum", {25'd0, sum8}, 33'd0);
    chk("abort cout", {32'd0, cout8}, 33'd0);
    chk("abort state", {31'd0, state8}, {31'd0, IDLE});
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("abort no done", 33'(ndone), 33'd0);
    op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, "01+02");

    // Back-to-back with start held high
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    ndone = 0;
    for (int idx = 1; idx <= 30; idx++) begin
      @(negedge clk);
      if (done8) begin
        ndone++;
        chk("b2b done pos", 33'(idx % 10), 33'd9);
        chk("b2b sum", {25'd0, sum8}, 33'h30);
        chk("b2b cout", {32'd0, cout8}, 33'd0);
      end
      if (idx == 29) start8 = 1'b0;
    end
    chk("b2b done count", 33'(ndone), 33'd3);

    // WIDTH=1 exhaustive
    for (int v = 0; v < 8; v++) op1(v);

    // Randomized traffic on both instances, with occasional resets
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rst    = ($urandom_range(0, 59) == 0);
      start8 = ($urandom_range(0, 3) == 0);
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      cin8   = 1'($urandom);
      start1 = ($urandom_range(0, 2) == 0);
      a1     = 1'($urandom);
      b1     = 1'($urandom);
      cin1   = 1'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0; start1 = 1'b0;
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_serial_add_ctrl
